// File: rtl/median_line_delay.sv
// median_line_delay: delays a pixel stream by exactly W accepted pixels
// (one image line) using a W-entry circular buffer with one shared
// read/write column pointer. Pixels are accepted only on edges with ce high.
// Output q stays 0 and valid stays low until the buffer has been filled once.
//
// Handshake: ce is a one-directional strobe with no back-pressure. Every
// clk edge with ce high and rst low accepts exactly one pixel on d. That
// same edge updates q and valid with the pixel accepted W pixels earlier.
// Edges with ce low change nothing.
module median_line_delay #(
    parameter int N = 8,
    parameter int W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [N-1:0]         d,
    output logic [N-1:0]         q,
    output logic                 valid,
    output logic [$clog2(W)-1:0] col
);

    localparam int CW = $clog2(W);
    localparam int FW = $clog2(W + 1);

    logic [N-1:0]  mem [W];
    logic [FW-1:0] fill;
    logic          full;

    // Once W pixels are stored, the word under col is the pixel from W pixels ago.
    assign full = (fill == FW'(W));

    // Line buffer write. There is no reset here so the buffer can map to RAM.
    // Stale contents are masked by the full flag.
    always_ff @(posedge clk) begin
        if (!rst && ce) begin
            mem[col] <= d;
        end
    end

    // Read-before-write output register, column pointer and fill counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
            col   <= '0;
            fill  <= '0;
        end else if (ce) begin
            q     <= full ? mem[col] : '0;
            valid <= full;
            if (col == CW'(W - 1)) begin
                col <= '0;
            end else begin
                col <= col + CW'(1);
            end
            if (!full) begin
                fill <= fill + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_median_line_delay.sv
// tb_median_line_delay: directed checks on a W=4 instance (fill, ce gaps,
// column wrap, mid-line reset, reset values) plus a random run on a W=64
// instance checked against a queue reference model.
module tb_median_line_delay;

    logic       clk = 1'b0;

    // W=4 instance
    logic       rst4 = 1'b1;
    logic       ce4  = 1'b0;
    logic [7:0] d4   = '0;
    logic [7:0] q4;
    logic       valid4;
    logic [1:0] col4;

    // W=64 instance
    logic       rst64 = 1'b1;
    logic       ce64  = 1'b0;
    logic [7:0] d64   = '0;
    logic [7:0] q64;
    logic       valid64;
    logic [5:0] col64;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];

    median_line_delay #(.N(8), .W(4)) dut4 (
        .clk   (clk),
        .rst   (rst4),
        .ce    (ce4),
        .d     (d4),
        .q     (q4),
        .valid (valid4),
        .col   (col4)
    );

    median_line_delay #(.N(8), .W(64)) dut64 (
        .clk   (clk),
        .rst   (rst64),
        .ce    (ce64),
        .d     (d64),
        .q     (q64),
        .valid (valid64),
        .col   (col64)
    );

    // clock and reset: 10 ns period
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: drive on negedge, sample 1 ns after the rising edge
    task automatic step4(input logic r, input logic c, input logic [7:0] dv);
        @(negedge clk);
        rst4 = r;
        ce4  = c;
        d4   = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic step64(input logic r, input logic c, input logic [7:0] dv);
        @(negedge clk);
        rst64 = r;
        ce64  = c;
        d64   = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [7:0] eq, input logic ev);
        check({tag, " q"}, {24'd0, q4}, {24'd0, eq});
        check({tag, " valid"}, {31'd0, valid4}, {31'd0, ev});
    endtask

    initial begin
        logic [7:0] hq;
        logic       hv;
        logic [7:0] eq;
        logic       ev;

        // ---------------- reset values ----------------
        step4(1'b1, 1'b0, 8'h00);
        check4("rst", 8'h00, 1'b0);
        check("rst col", {30'd0, col4}, 32'd0);

        // ---------------- fill test: d=1..10 ----------------
        for (int k = 1; k <= 10; k++) begin
            step4(1'b0, 1'b1, 8'(k));
            check4($sformatf("fill k=%0d", k), (k > 4) ? 8'(k - 4) : 8'h00, k > 4);
            check($sformatf("fill col k=%0d", k), {30'd0, col4}, 32'(k % 4));
        end

        // ---------------- gap test: ce 1,0,0 ----------------
        step4(1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 8; k++) begin
            step4(1'b0, 1'b1, 8'(k));
            hq = (k > 4) ? 8'(k - 4) : 8'h00;
            hv = (k > 4);
            check4($sformatf("gap k=%0d", k), hq, hv);
            for (int g = 0; g < 2; g++) begin
                step4(1'b0, 1'b0, 8'hEE);
                check4($sformatf("gap hold k=%0d g=%0d", k, g), hq, hv);
                check($sformatf("gap hold col k=%0d g=%0d", k, g), {30'd0, col4}, 32'(k % 4));
            end
        end

        // ---------------- wrap test: 13 pixels ----------------
        step4(1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 13; k++) begin
            check($sformatf("wrap col before k=%0d", k), {30'd0, col4}, 32'((k - 1) % 4));
            step4(1'b0, 1'b1, 8'(8'h10 + k));
            check4($sformatf("wrap k=%0d", k), (k > 4) ? 8'(8'h10 + k - 4) : 8'h00, k > 4);
        end

        // ---------------- mid-operation reset ----------------
        step4(1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 6; k++) begin
            step4(1'b0, 1'b1, 8'(8'h30 + k));
        end
        check4("pre-midrst", 8'h32, 1'b1);
        step4(1'b1, 1'b1, 8'h55);
        check4("midrst", 8'h00, 1'b0);
        check("midrst col", {30'd0, col4}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step4(1'b0, 1'b1, 8'(8'hA0 + k - 1));
            check4($sformatf("after midrst k=%0d", k), (k > 4) ? 8'(8'hA0 + k - 5) : 8'h00, k > 4);
        end

        // ---------------- reset value with prior state, then idle ----------------
        step4(1'b1, 1'b0, 8'h77);
        check4("rst2", 8'h00, 1'b0);
        check("rst2 col", {30'd0, col4}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step4(1'b0, 1'b0, 8'h99);
            check4($sformatf("rst2 idle %0d", i), 8'h00, 1'b0);
            check($sformatf("rst2 idle col %0d", i), {30'd0, col4}, 32'd0);
        end

        // ---------------- random test on W=64 ----------------
        step64(1'b1, 1'b0, 8'h00);
        check("r64 rst q", {24'd0, q64}, 32'd0);
        check("r64 rst valid", {31'd0, valid64}, 32'd0);
        check("r64 rst col", {26'd0, col64}, 32'd0);
        eq = 8'h00;
        ev = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            logic       c;
            logic [7:0] dv;
            c  = 1'($urandom_range(0, 1));
            dv = 8'($urandom_range(0, 255));
            step64(1'b0, c, dv);
            if (c) begin
                if (exp_q.size() == 64) begin
                    eq = exp_q.pop_front();
                    ev = 1'b1;
                end else begin
                    eq = 8'h00;
                    ev = 1'b0;
                end
                exp_q.push_back(dv);
            end
            check($sformatf("r64 q i=%0d", i), {24'd0, q64}, {24'd0, eq});
            check($sformatf("r64 valid i=%0d", i), {31'd0, valid64}, {31'd0, ev});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
